// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output stream among N requesters.
// Latency: request seen in cycle 0 -> grant in cycle 1 -> beat on outValid in cycle 2.
// Backpressure: inReady[grant] = !outValid || outReady, so a stalled output stalls the grantee.
// Optional STREAM_ARB_PKT_LOCK_EN: hold the grant until a beat with inLast=1;
// without it the grant is released after every beat.
`timescale 1ns/1ps

module stream_rr_arbiter #(
  parameter  int N  = 4,
  parameter  int W  = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    inValid,
  input  logic [N-1:0]    inLast,
  input  logic [N*W-1:0]  dIn,
  output logic [N-1:0]    inReady,
  output logic            outValid,
  input  logic            outReady,
  output logic [W-1:0]    dOut,
  output logic            outLast,
  output logic [SW-1:0]   outSel
);

`ifdef STREAM_ARB_PKT_LOCK_EN
  localparam bit PKT_LOCK = 1'b1;
`else
  localparam bit PKT_LOCK = 1'b0;
`endif

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  grant_q, grant_d;
  logic [SW-1:0]  last_grant_q, last_grant_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   dout_q, dout_d;
  logic           out_last_q, out_last_d;
  logic [SW-1:0]  out_sel_q, out_sel_d;

  logic           space;
  logic           xfer;
  logic           release_grant;
  logic           gnt_valid;
  logic           gnt_last;
  logic [W-1:0]   gnt_data;
  logic [SW-1:0]  rr_pick;
  logic           any_valid;
  logic [N-1:0]   in_ready_c;

  // The output register can take a new beat when empty or draining this cycle.
  assign space = !out_valid_q || outReady;

  // Mux the granted requester's signals out of the flat input buses.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_q == SW'(i)) begin
        gnt_valid = inValid[i];
        gnt_last  = inLast[i];
        gnt_data  = dIn[i*W +: W];
      end
    end
  end

  // Only the grantee ever sees ready, and only from registered state plus outReady.
  always_comb begin
    in_ready_c = '0;
    for (int i = 0; i < N; i++) begin
      in_ready_c[i] = (state_q == LOCKED) && (grant_q == SW'(i)) && space;
    end
  end

  assign xfer          = (state_q == LOCKED) && gnt_valid && space;
  assign release_grant = xfer && (gnt_last || !PKT_LOCK);

  // Round-robin search: first valid requester strictly after the last one served.
  always_comb begin
    rr_pick   = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!any_valid && (j == (int'(last_grant_q) + k) % N) && inValid[j]) begin
          rr_pick   = SW'(j);
          any_valid = 1'b1;
        end
      end
    end
  end

  // Grant state machine: pick in IDLE, hold in LOCKED until the grant is released.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d = rr_pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (release_grant) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: load on transfer, clear valid on drain, otherwise hold.
  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    out_last_d  = out_last_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      dout_d      = gnt_data;
      out_last_d  = gnt_last;
      out_sel_d   = grant_q;
    end else if (out_valid_q && outReady) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers; reset drops any in-flight beat.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= SW'(N - 1);
      out_valid_q  <= 1'b0;
      dout_q       <= '0;
      out_last_q   <= 1'b0;
      out_sel_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      dout_q       <= dout_d;
      out_last_q   <= out_last_d;
      out_sel_q    <= out_sel_d;
    end
  end

  assign inReady  = in_ready_c;
  assign outValid = out_valid_q;
  assign dOut     = dout_q;
  assign outLast  = out_last_q;
  assign outSel   = out_sel_q;

endmodule
